// File: rtl/mst_imp_wr_fill.sv
// AXI4-lite write master that fills a HSIZE x VSIZE rectangle, one beat per pixel.
// AW and W run independently; AW is throttled by the number of unanswered writes.
module mst_imp_wr_fill #(
   parameter int DW       = 32,
   parameter int AW       = 32,
   parameter int CW       = 8,
   parameter int MAX_OUTS = 4
) (
   input  logic            clk,
   input  logic            rst,
   output logic            mem_axi_awvalid,
   input  logic            mem_axi_awready,
   output logic [AW-1:0]   mem_axi_awaddr,
   output logic [2:0]      mem_axi_awprot,
   output logic            mem_axi_wvalid,
   input  logic            mem_axi_wready,
   output logic [DW-1:0]   mem_axi_wdata,
   output logic [DW/8-1:0] mem_axi_wstrb,
   input  logic            mem_axi_bvalid,
   input  logic [1:0]      mem_axi_bresp,
   output logic            mem_axi_bready,
   input  logic [CW-1:0]   IMP_HSIZE,
   input  logic [CW-1:0]   IMP_VSIZE,
   input  logic [AW-1:0]   IMP_DST_BADDR,
   input  logic [AW-1:0]   IMP_ADR_PITCH,
   input  logic [1:0]      IMP_MODE,
   input  logic [DW-1:0]   IMP_FILL_DATA,
   input  logic            IMP_ST,
   output logic            IMP_BUSY,
   output logic            IMP_DONE,
   output logic            IMP_ERR,
   input  logic            IMP_ERR_CLR,
   output logic [1:0]      o_dbg_state
);

   localparam int BPB = DW / 8;
   localparam int NW  = 2 * CW;
   localparam int OW  = 4;

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

   state_t          r_state, w_state_nxt;
   logic [CW-1:0]   r_hsize;
   logic [NW-1:0]   r_total;
   logic [AW-1:0]   r_pitch;
   logic [1:0]      r_mode;
   logic [DW-1:0]   r_fill;
   logic            r_aw_pend;
   logic [CW-1:0]   r_aw_x;
   logic [NW-1:0]   r_aw_n;
   logic [AW-1:0]   r_line_base;
   logic [AW-1:0]   r_awaddr;
   logic            r_wvalid;
   logic [CW-1:0]   r_w_x;
   logic [CW-1:0]   r_w_y;
   logic [NW-1:0]   r_w_n;
   logic [DW-1:0]   r_wdata;
   logic [OW-1:0]   r_outs;
   logic            r_done;
   logic            r_err;

   logic            w_aw_hs, w_w_hs, w_b_hs;
   logic            w_aw_last, w_w_last;
   logic            w_start, w_nonzero;
   logic            w_w_wrap;
   logic [CW-1:0]   w_wx_nxt, w_wy_nxt;
   logic [OW-1:0]   w_outs_nxt;

   function automatic logic [DW-1:0] f_data(input logic [1:0] mode, input logic [DW-1:0] fill,
                                            input logic [NW-1:0] n, input logic [CW-1:0] x,
                                            input logic [CW-1:0] y);
      logic [DW-1:0] v;
      v = fill;
      case (mode)
         2'd1: v = fill + DW'(n);
         2'd2: begin
            v = '0;
            v[CW-1:0]    = x;
            v[2*CW-1:CW] = y;
         end
         default: v = fill;
      endcase
      return v;
   endfunction

   // A B response with nothing outstanding is a protocol violation and is dropped.
   assign w_b_hs    = mem_axi_bvalid && (r_outs != '0);
   assign mem_axi_awvalid = r_aw_pend && ((r_outs != OW'(MAX_OUTS)) || w_b_hs);
   assign w_aw_hs   = mem_axi_awvalid && mem_axi_awready;
   assign w_w_hs    = r_wvalid && mem_axi_wready;
   assign w_aw_last = (r_aw_n == r_total - NW'(1));
   assign w_w_last  = (r_w_n == r_total - NW'(1));
   assign w_start   = (r_state == S_IDLE) && IMP_ST;
   assign w_nonzero = (IMP_HSIZE != '0) && (IMP_VSIZE != '0);
   assign w_w_wrap  = (r_w_x == r_hsize - CW'(1));
   assign w_wx_nxt  = w_w_wrap ? '0 : r_w_x + CW'(1);
   assign w_wy_nxt  = w_w_wrap ? r_w_y + CW'(1) : r_w_y;

   always_comb begin
      w_outs_nxt = r_outs;
      if (w_aw_hs && !w_b_hs)
         w_outs_nxt = r_outs + OW'(1);
      else if (!w_aw_hs && w_b_hs)
         w_outs_nxt = r_outs - OW'(1);
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_IDLE:  if (IMP_ST) w_state_nxt = w_nonzero ? S_RUN : S_DONE;
         S_RUN:   if ((!r_aw_pend || (w_aw_hs && w_aw_last)) &&
                      (!r_wvalid || (w_w_hs && w_w_last)))
                     w_state_nxt = S_DRAIN;
         S_DRAIN: if (w_outs_nxt == '0) w_state_nxt = S_DONE;
         default: w_state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst)
         r_state <= S_IDLE;
      else
         r_state <= w_state_nxt;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_hsize <= '0;  r_total <= '0;  r_pitch <= '0;  r_mode <= '0;  r_fill <= '0;
         r_aw_pend <= 1'b0;  r_aw_x <= '0;  r_aw_n <= '0;  r_line_base <= '0;  r_awaddr <= '0;
         r_wvalid <= 1'b0;  r_w_x <= '0;  r_w_y <= '0;  r_w_n <= '0;  r_wdata <= '0;
         r_outs <= '0;  r_done <= 1'b0;  r_err <= 1'b0;
      end else begin
         r_outs <= w_outs_nxt;
         r_done <= (r_state == S_DONE);
         if (w_b_hs && (mem_axi_bresp != 2'b00))
            r_err <= 1'b1;
         else if (IMP_ERR_CLR)
            r_err <= 1'b0;

         if (w_start) begin
            r_hsize     <= IMP_HSIZE;
            r_total     <= NW'(IMP_HSIZE) * NW'(IMP_VSIZE);
            r_pitch     <= IMP_ADR_PITCH;
            r_mode      <= IMP_MODE;
            r_fill      <= IMP_FILL_DATA;
            r_aw_pend   <= w_nonzero;
            r_aw_x      <= '0;
            r_aw_n      <= '0;
            r_line_base <= IMP_DST_BADDR;
            r_awaddr    <= IMP_DST_BADDR;
            r_wvalid    <= w_nonzero;
            r_w_x       <= '0;
            r_w_y       <= '0;
            r_w_n       <= '0;
            r_wdata     <= f_data(IMP_MODE, IMP_FILL_DATA, '0, '0, '0);
         end else begin
            if (w_aw_hs) begin
               if (w_aw_last) begin
                  r_aw_pend <= 1'b0;
               end else begin
                  r_aw_n <= r_aw_n + NW'(1);
                  if (r_aw_x != r_hsize - CW'(1)) begin
                     r_aw_x   <= r_aw_x + CW'(1);
                     r_awaddr <= r_awaddr + AW'(BPB);
                  end else begin
                     r_aw_x      <= '0;
                     r_line_base <= r_line_base + r_pitch;
                     r_awaddr    <= r_line_base + r_pitch;
                  end
               end
            end
            if (w_w_hs) begin
               if (w_w_last) begin
                  r_wvalid <= 1'b0;
               end else begin
                  r_w_n   <= r_w_n + NW'(1);
                  r_w_x   <= w_wx_nxt;
                  r_w_y   <= w_wy_nxt;
                  r_wdata <= f_data(r_mode, r_fill, r_w_n + NW'(1), w_wx_nxt, w_wy_nxt);
               end
            end
         end
      end
   end

   assign mem_axi_awaddr = r_awaddr;
   assign mem_axi_awprot = 3'b000;
   assign mem_axi_wvalid = r_wvalid;
   assign mem_axi_wdata  = r_wdata;
   assign mem_axi_wstrb  = '1;
   assign mem_axi_bready = 1'b1;
   assign IMP_BUSY       = (r_state != S_IDLE);
   assign IMP_DONE       = r_done;
   assign IMP_ERR        = r_err;
   assign o_dbg_state    = r_state;

endmodule

// File: tb/tb_mst_imp_wr_fill.sv
// Bench for mst_imp_wr_fill: random-ready AXI slave, expected address/data queues built
// from the rectangle geometry, and one per-cycle compare process.
module tb_mst_imp_wr_fill;
   localparam int DW = 32;
   localparam int AW = 32;
   localparam int CW = 8;
   localparam int MAX_OUTS = 2;

   logic            clk = 1'b0;
   logic            rst;
   logic            awvalid, awready, wvalid, wready, bvalid, bready;
   logic [AW-1:0]   awaddr;
   logic [2:0]      awprot;
   logic [DW-1:0]   wdata;
   logic [DW/8-1:0] wstrb;
   logic [1:0]      bresp;
   logic [CW-1:0]   imp_hsize, imp_vsize;
   logic [AW-1:0]   imp_baddr, imp_pitch;
   logic [1:0]      imp_mode;
   logic [DW-1:0]   imp_fill;
   logic            imp_st, imp_busy, imp_done, imp_err, imp_err_clr;
   logic [1:0]      dbg_state;

   mst_imp_wr_fill #(.DW(DW), .AW(AW), .CW(CW), .MAX_OUTS(MAX_OUTS)) dut (
      .clk(clk), .rst(rst),
      .mem_axi_awvalid(awvalid), .mem_axi_awready(awready), .mem_axi_awaddr(awaddr),
      .mem_axi_awprot(awprot), .mem_axi_wvalid(wvalid), .mem_axi_wready(wready),
      .mem_axi_wdata(wdata), .mem_axi_wstrb(wstrb), .mem_axi_bvalid(bvalid),
      .mem_axi_bresp(bresp), .mem_axi_bready(bready),
      .IMP_HSIZE(imp_hsize), .IMP_VSIZE(imp_vsize), .IMP_DST_BADDR(imp_baddr),
      .IMP_ADR_PITCH(imp_pitch), .IMP_MODE(imp_mode), .IMP_FILL_DATA(imp_fill),
      .IMP_ST(imp_st), .IMP_BUSY(imp_busy), .IMP_DONE(imp_done), .IMP_ERR(imp_err),
      .IMP_ERR_CLR(imp_err_clr), .o_dbg_state(dbg_state)
   );

   // ---------------- clock / reset ----------------
   initial forever #5 clk = ~clk;

   int cyc = 0;
   initial forever begin
      @(posedge clk);
      cyc++;
   end

   // ---------------- scoreboard state ----------------
   int checks = 0;
   int errors = 0;
   logic [AW-1:0] exp_aw_q[$];
   logic [DW-1:0] exp_w_q[$];
   int  n_aw, n_w, n_b, n_done, n_valid_cycles;
   int  model_outs = 0;
   logic exp_err = 1'b0;
   int  st_cyc, done_lat;
   bit  mon_aw_hs, mon_b_hs;
   bit  prev_aw_stall, prev_w_stall;
   logic [AW-1:0] prev_awaddr;
   logic [DW-1:0] prev_wdata;

   // slave knobs
   int aw_pct = 100, w_pct = 100, b_pct = 100;
   int b_budget = 1000000;
   int b_err_idx = -1;
   int b_owed = 0, b_sent = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   task automatic fail(input string name);
      checks++;
      errors++;
      $display("FAIL %s actual=missing-or-extra required=none", name);
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // ---------------- AXI slave driver ----------------
   initial begin
      awready = 1'b0; wready = 1'b0; bvalid = 1'b0; bresp = 2'b00;
      forever begin
         @(posedge clk);
         if (rst) begin
            b_owed = 0;
         end else begin
            if (mon_aw_hs) b_owed++;
            if (mon_b_hs) begin
               b_owed--;
               b_sent++;
               b_budget--;
            end
         end
         #1;
         awready = ($urandom_range(0, 99) < aw_pct);
         wready  = ($urandom_range(0, 99) < w_pct);
         bvalid  = (b_owed > 0) && (b_budget > 0) && ($urandom_range(0, 99) < b_pct);
         bresp   = (b_sent == b_err_idx) ? 2'b10 : 2'b00;
      end
   end

   // ---------------- per-cycle compare ----------------
   initial forever begin
      bit aw_hs, w_hs, b_hs;
      @(negedge clk);
      mon_aw_hs = 1'b0;
      mon_b_hs  = 1'b0;
      if (rst) begin
         model_outs = 0; exp_err = 1'b0; prev_aw_stall = 1'b0; prev_w_stall = 1'b0;
      end else begin
         aw_hs = awvalid && awready;
         w_hs  = wvalid && wready;
         b_hs  = bvalid && bready && (model_outs > 0);
         check("err_flag", imp_err, exp_err);
         if (awvalid || wvalid) n_valid_cycles++;
         if (prev_aw_stall) check("aw_hold", {awvalid, awaddr}, {1'b1, prev_awaddr});
         if (prev_w_stall)  check("w_hold", {wvalid, wdata}, {1'b1, prev_wdata});
         if (aw_hs) begin
            if (exp_aw_q.size() == 0) fail("aw_extra");
            else check("awaddr", awaddr, exp_aw_q.pop_front());
            n_aw++;
         end
         if (w_hs) begin
            if (exp_w_q.size() == 0) fail("w_extra");
            else check("wdata", wdata, exp_w_q.pop_front());
            n_w++;
         end
         if (model_outs == MAX_OUTS && !b_hs) check("aw_gate", awvalid, 1'b0);
         model_outs = model_outs + int'(aw_hs) - int'(b_hs);
         if (b_hs) n_b++;
         if (imp_done) n_done++;
         if (b_hs && bresp != 2'b00) exp_err = 1'b1;
         else if (imp_err_clr) exp_err = 1'b0;
         prev_aw_stall = awvalid && !awready;
         prev_w_stall  = wvalid && !wready;
         prev_awaddr   = awaddr;
         prev_wdata    = wdata;
         mon_aw_hs = aw_hs;
         mon_b_hs  = b_hs;
      end
   end

   // ---------------- reference model: geometry -> expected beats ----------------
   task automatic build(input int h, input int v, input logic [AW-1:0] ba, input logic [AW-1:0] pi,
                        input int mode, input logic [DW-1:0] fill);
      exp_aw_q.delete();
      exp_w_q.delete();
      for (int y = 0; y < v; y++) begin
         for (int x = 0; x < h; x++) begin
            int n;
            n = y * h + x;
            exp_aw_q.push_back(ba + AW'(y) * pi + AW'(x * (DW / 8)));
            case (mode)
               1:       exp_w_q.push_back(fill + DW'(n));
               2:       exp_w_q.push_back(DW'((y << CW) | x));
               default: exp_w_q.push_back(fill);
            endcase
         end
      end
   endtask

   task automatic start_fill(input int h, input int v, input logic [AW-1:0] ba,
                             input logic [AW-1:0] pi, input int mode, input logic [DW-1:0] fill);
      n_aw = 0; n_w = 0; n_b = 0; n_done = 0; n_valid_cycles = 0; b_sent = 0;
      imp_hsize = CW'(h); imp_vsize = CW'(v); imp_baddr = ba; imp_pitch = pi;
      imp_mode = 2'(mode); imp_fill = fill;
      imp_st = 1'b1;
      st_cyc = cyc;
      step();
      imp_st = 1'b0;
   endtask

   task automatic wait_done(input int limit);
      bit got;
      got = 1'b0;
      for (int i = 0; i < limit && !got; i++) begin
         @(negedge clk);
         if (imp_done) begin
            got = 1'b1;
            done_lat = cyc - st_cyc;
         end
      end
      if (!got) fail("done_timeout");
      step();
   endtask

   task automatic finish_check(input int beats, input int lat, input logic err);
      repeat (3) step();
      check("done_pulses", n_done, 1);
      check("aw_left", exp_aw_q.size(), 0);
      check("w_left", exp_w_q.size(), 0);
      check("aw_count", n_aw, beats);
      check("w_count", n_w, beats);
      check("b_count", n_b, beats);
      if (lat >= 0) check("latency", done_lat, lat);
      check("err_final", imp_err, err);
   endtask

   task automatic set_rates(input int a, input int w, input int b);
      aw_pct = a; w_pct = w; b_pct = b;
   endtask

   // ---------------- test sequence ----------------
   initial begin
      rst = 1'b1; imp_st = 1'b0; imp_err_clr = 1'b0;
      imp_hsize = '0; imp_vsize = '0; imp_baddr = '0; imp_pitch = '0; imp_mode = '0; imp_fill = '0;
      repeat (3) step();
      @(negedge clk);
      check("rst_awvalid", awvalid, 1'b0);
      check("rst_wvalid", wvalid, 1'b0);
      check("rst_awaddr", awaddr, 32'h0);
      check("rst_wdata", wdata, 32'h0);
      check("rst_busy", imp_busy, 1'b0);
      check("rst_done", imp_done, 1'b0);
      check("rst_err", imp_err, 1'b0);
      check("bready", bready, 1'b1);
      check("wstrb", wstrb, 4'hF);
      check("awprot", awprot, 3'b000);
      step();
      rst = 1'b0;
      step();

      // constant fill 4x3, all ready
      set_rates(100, 100, 100);
      build(4, 3, 32'h1000, 32'h100, 0, 32'hA5A5A5A5);
      check("pin_aw4", exp_aw_q[4], 32'h1100);
      check("pin_aw11", exp_aw_q[11], 32'h120C);
      check("pin_w0", exp_w_q[0], 32'hA5A5A5A5);
      start_fill(4, 3, 32'h1000, 32'h100, 0, 32'hA5A5A5A5);
      @(negedge clk);
      check("busy_run", imp_busy, 1'b1);
      wait_done(200);
      finish_check(12, 15, 1'b0);

      // incrementing fill wraps through zero
      build(4, 1, 32'h0, 32'h0, 1, 32'hFFFFFFFE);
      check("pin_m1_0", exp_w_q[0], 32'hFFFFFFFE);
      check("pin_m1_1", exp_w_q[1], 32'hFFFFFFFF);
      check("pin_m1_2", exp_w_q[2], 32'h00000000);
      check("pin_m1_3", exp_w_q[3], 32'h00000001);
      start_fill(4, 1, 32'h0, 32'h0, 1, 32'hFFFFFFFE);
      wait_done(200);
      finish_check(4, 7, 1'b0);

      // coordinate fill with random stalls on every channel
      set_rates(50, 50, 60);
      build(2, 2, 32'h8000, 32'h20, 2, 32'h0);
      check("pin_m2_2", exp_w_q[2], 32'h0100);
      check("pin_m2_3", exp_w_q[3], 32'h0101);
      start_fill(2, 2, 32'h8000, 32'h20, 2, 32'h0);
      wait_done(400);
      finish_check(4, -1, 1'b0);

      // outstanding limit with B withheld, then a single release
      set_rates(100, 100, 100);
      b_budget = 0;
      build(3, 2, 32'h2000, 32'h40, 1, 32'h10);
      start_fill(3, 2, 32'h2000, 32'h40, 1, 32'h10);
      repeat (12) step();
      @(negedge clk);
      check("outs_aw_blocked", n_aw, 2);
      check("outs_w_free", n_w, 6);
      check("outs_awvalid", awvalid, 1'b0);
      check("outs_busy", imp_busy, 1'b1);
      step();
      b_budget = 1;
      repeat (6) step();
      check("release_aw", n_aw, 3);
      check("release_b", n_b, 1);
      check("release_awvalid", awvalid, 1'b0);
      b_budget = 1000000;
      wait_done(200);
      finish_check(6, -1, 1'b0);

      // error response on the 5th of 8 writes
      set_rates(70, 70, 70);
      b_err_idx = 4;
      build(4, 2, 32'hFFFF_FFF0, 32'h10, 0, 32'h5A5A0000);
      start_fill(4, 2, 32'hFFFF_FFF0, 32'h10, 0, 32'h5A5A0000);
      wait_done(400);
      finish_check(8, -1, 1'b1);
      b_err_idx = -1;
      imp_err_clr = 1'b1;
      step();
      imp_err_clr = 1'b0;
      @(negedge clk);
      check("err_cleared", imp_err, 1'b0);
      step();

      // start request and config changes while busy are ignored
      set_rates(100, 100, 100);
      build(4, 4, 32'h3000, 32'h80, 2, 32'h0);
      start_fill(4, 4, 32'h3000, 32'h80, 2, 32'h0);
      repeat (3) step();
      imp_hsize = 8'd1; imp_vsize = 8'd1; imp_baddr = 32'h9000; imp_mode = 2'd0;
      imp_st = 1'b1;
      step();
      imp_st = 1'b0;
      wait_done(200);
      finish_check(16, 19, 1'b0);

      // zero-size transfers
      build(0, 5, 32'h5000, 32'h0, 0, 32'h1);
      start_fill(0, 5, 32'h5000, 32'h0, 0, 32'h1);
      wait_done(20);
      finish_check(0, 2, 1'b0);
      check("zero_h_valids", n_valid_cycles, 0);
      build(3, 0, 32'h5000, 32'h0, 0, 32'h1);
      start_fill(3, 0, 32'h5000, 32'h0, 0, 32'h1);
      wait_done(20);
      finish_check(0, 2, 1'b0);
      check("zero_v_valids", n_valid_cycles, 0);

      // reset mid-row, then restart from the base address
      build(8, 2, 32'h4000, 32'h100, 0, 32'h77);
      start_fill(8, 2, 32'h4000, 32'h100, 0, 32'h77);
      repeat (3) step();
      rst = 1'b1;
      step();
      @(negedge clk);
      check("abort_awvalid", awvalid, 1'b0);
      check("abort_wvalid", wvalid, 1'b0);
      check("abort_busy", imp_busy, 1'b0);
      exp_aw_q.delete();
      exp_w_q.delete();
      step();
      rst = 1'b0;
      step();
      build(2, 1, 32'h4000, 32'h100, 1, 32'h20);
      start_fill(2, 1, 32'h4000, 32'h100, 1, 32'h20);
      wait_done(200);
      finish_check(2, 5, 1'b0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog actual=running required=finished");
      $fatal(1, "watchdog expired");
   end

endmodule

// File: doc/mst_imp_wr_fill.md
Name: mst_imp_wr_fill

Overview:
- Parametrised AXI4-lite write master that fills a 2-D rectangle in memory, one data word per pixel beat, row by row.
- Successor to the single-channel image write master. Adds:
  - true AW/W/B handshaking with valid-hold;
  - a bounded outstanding-write count;
  - selectable data patterns;
  - completion and error reporting.
- Sits on the SoC AXI4-lite interconnect as a master and is configured by register-block signals.

Parameters:
- DW, 32, AXI data width in bits; legal values 32 or 64; bytes per beat BPB = DW/8.
- AW, 32, AXI address width.
- CW, 8, width of the HSIZE/VSIZE and x/y counters.
- MAX_OUTS, 4, maximum AW beats issued without a B response; legal range 1..15.

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- mem_axi_awvalid  out  1  write address valid.
- mem_axi_awready  in  1  write address ready.
- mem_axi_awaddr  out  AW  write address.
- mem_axi_awprot  out  3  tied 3'b000.
- mem_axi_wvalid  out  1  write data valid.
- mem_axi_wready  in  1  write data ready.
- mem_axi_wdata  out  DW  write data.
- mem_axi_wstrb  out  DW/8  all ones.
- mem_axi_bvalid  in  1  write response valid.
- mem_axi_bresp  in  2  write response code.
- mem_axi_bready  out  1  write response ready; held 1.
- IMP_HSIZE  in  CW  pixels (beats) per row.
- IMP_VSIZE  in  CW  number of rows.
- IMP_DST_BADDR  in  AW  address of the first pixel; must be BPB-aligned.
- IMP_ADR_PITCH  in  AW  bytes between row starts.
- IMP_MODE  in  2  data pattern: 0 = constant, 1 = incrementing, 2 = coordinate, 3 = reserved (behaves as 0).
- IMP_FILL_DATA  in  DW  constant value / increment seed.
- IMP_ST  in  1  start request; sampled only in IDLE.
- IMP_BUSY  out  1  high from the cycle after start acceptance until DONE.
- IMP_DONE  out  1  one-cycle pulse on completion.
- IMP_ERR  out  1  sticky; set by any bresp != 2'b00.
- IMP_ERR_CLR  in  1  clears IMP_ERR.

Behaviour:
- Reset values: awvalid=0, wvalid=0, awaddr=0, wdata=0, IMP_BUSY=0, IMP_DONE=0, IMP_ERR=0, all counters 0, state IDLE. bready=1 and wstrb all ones are constant.
- Synchronous reset mid-transfer aborts immediately: valids drop the next edge and no further beats are issued. Responses still in flight are ignored; the interconnect must be reset together with this block.
- States:
  - IDLE: when IMP_ST=1, latch all IMP_* configuration inputs.
    - If HSIZE=0 or VSIZE=0, go to DONE.
    - Otherwise go to RUN. awvalid and wvalid assert on the cycle after IMP_ST.
  - RUN: AW and W channels proceed independently.
    - Go to DRAIN once the last AW handshake and the last W handshake have both occurred.
  - DRAIN: wait until the outstanding count is 0 and every B response has been received. Then go to DONE.
  - DONE: IMP_DONE=1 for exactly one cycle, IMP_BUSY drops, return to IDLE.
- IMP_ST outside IDLE is ignored. Configuration inputs may change after start without effect.
- AW channel:
  - x/y counters plus a line base register. First awaddr = BADDR.
  - On each AW handshake: if x < HSIZE-1, then x++ and awaddr += BPB. Otherwise x=0, y++, line_base += PITCH, awaddr = new line_base.
  - Address arithmetic wraps modulo 2^AW.
  - awvalid, once high, stays high with a stable awaddr until awready. It drops the cycle after the final (HSIZE*VSIZE-th) handshake.
  - Outstanding counter: +1 on an AW handshake, -1 on a B handshake, unchanged when both happen in the same cycle.
  - awvalid is deasserted (never asserted) while outstanding == MAX_OUTS and no B handshake is occurring that cycle.
- W channel:
  - Has its own x/y beat counters and a beat index n, starting at 0.
  - wvalid stays high with stable wdata until wready. It drops after the final beat.
  - W may lead or lag AW; W beats are not limited by MAX_OUTS.
  - wdata by mode:
    - mode 0: FILL_DATA.
    - mode 1: FILL_DATA + n, mod 2^DW.
    - mode 2: {zero, y[CW-1:0], x[CW-1:0]}, where x/y are the W-channel coordinates of the beat.
- B channel:
  - bresp != 0 sets IMP_ERR. The transfer still completes and the fill is not aborted.
  - If IMP_ERR_CLR and a new error occur in the same cycle, set wins.
  - A B response arriving while outstanding == 0 (protocol violation) is ignored; the counter must not underflow.
- Total beats = HSIZE*VSIZE, computed at 2*CW bits without overflow.
- Latency from IMP_ST to IMP_DONE with ready always high and B returned 1 cycle after AW: HSIZE*VSIZE + 3 cycles. Zero-size: IMP_DONE 2 cycles after IMP_ST, no AXI activity.

Test Plan:
- HSIZE=4, VSIZE=3, BADDR=0x1000, PITCH=0x100, mode 0, FILL=0xA5A5A5A5, all ready=1:
  - awaddr sequence 0x1000,0x1004,0x1008,0x100C,0x1100,…,0x120C;
  - 12 beats of 0xA5A5A5A5;
  - exactly 12 B responses consumed, one IMP_DONE pulse, IMP_ERR=0.
- Mode 1, FILL=0xFFFFFFFE, HSIZE=4, VSIZE=1 -> wdata 0xFFFFFFFE, 0xFFFFFFFF, 0x00000000, 0x00000001.
- Mode 2, HSIZE=2, VSIZE=2, random awready/wready stalls -> wdata 0x0000, 0x0001, 0x0100, 0x0101; awaddr and wdata stable throughout every stall.
- MAX_OUTS=2, bvalid withheld:
  - after 2 AW handshakes awvalid=0 while W continues;
  - releasing one B re-enables AW;
  - simultaneous AW and B handshakes leave the count unchanged.
- bresp=2'b10 on beat 5 of 8 -> IMP_ERR=1 stays set, all 8 beats still issued, IMP_DONE pulses; IMP_ERR_CLR then clears it.
- Edge cases:
  - HSIZE=0 -> IMP_DONE 2 cycles after IMP_ST, no valids;
  - IMP_ST repeated while busy -> ignored;
  - rst asserted mid-row -> valids=0 and BUSY=0 next cycle;
  - a new start afterwards restarts at BADDR.
